rob_commit_unit: RTL and testbench

//  In-order commit buffer (reorder buffer) feeding the architectural register file write port.

---
 rtl/rob_commit_unit.sv | 134 +++++++++++++
 tb/tb_rob_commit_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// In-order commit buffer (reorder buffer). Dispatch allocates entries at the
// tail, CDB results mark entries DONE, and the head entry retires onto the
// register-file write port one per cycle, strictly in program order.
// Handshake: a dispatch is accepted on a rising edge where disp_valid and
// disp_ready are both high; disp_tag names the entry it receives. CDB and
// writeback are valid-only (no backpressure). wb_* are registered pulses.
module rob_commit_unit #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int ADDR  = 5,
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               disp_valid,
  input  logic [ADDR-1:0]    disp_rd,
  output logic               disp_ready,
  output logic [TAG_W-1:0]   disp_tag,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [WIDTH-1:0]   cdb_data,
  output logic               wb_commit,
  output logic [ADDR-1:0]    wb_reg,
  output logic [WIDTH-1:0]   wb_data,
  output logic [TAG_W:0]     count,
  output logic [2*DEPTH-1:0] dbg_state
);

  typedef enum logic [1:0] {
    E_FREE   = 2'd0,
    E_ISSUED = 2'd1,
    E_DONE   = 2'd2
  } ent_state_e;

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  ent_state_e       st_q [DEPTH];
  ent_state_e       st_d [DEPTH];
  logic [ADDR-1:0]  rd_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic             wb_commit_d;
  logic [ADDR-1:0]  wb_reg_d;
  logic [WIDTH-1:0] wb_data_d;

  logic disp_fire;
  logic cdb_hit;
  logic commit_fire;

  // A full buffer refuses dispatch even if the head retires this cycle.
  assign disp_ready  = (count_q != FULL_CNT) && !flush;
  assign disp_tag    = tail_q;
  assign count       = count_q;
  assign disp_fire   = disp_valid && disp_ready;
  // Only ISSUED entries accept a result; late or duplicate broadcasts drop.
  assign cdb_hit     = cdb_valid && (st_q[cdb_tag] == E_ISSUED) && !flush;
  // Decided from registered state only, so a same-cycle CDB never bypasses.
  assign commit_fire = (st_q[head_q] == E_DONE) && !flush;

  // State register: entry states, pointers, occupancy and writeback port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= E_FREE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wb_commit <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
    end else begin
      st_q      <= st_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wb_commit <= wb_commit_d;
      wb_reg    <= wb_reg_d;
      wb_data   <= wb_data_d;
    end
  end

  // Payload storage; contents of FREE entries are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (disp_fire) rd_q[tail_q]    <= disp_rd;
    if (cdb_hit)   data_q[cdb_tag] <= cdb_data;
  end

  // Next-state: per-entry lifecycle plus pointer/occupancy bookkeeping.
  always_comb begin
    st_d    = st_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = E_FREE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_fire) begin
        st_d[head_q] = E_FREE;
        head_d       = head_q + TAG_W'(1);
      end
      if (cdb_hit) st_d[cdb_tag] = E_DONE;
      if (disp_fire) begin
        st_d[tail_q] = E_ISSUED;
        tail_d       = tail_q + TAG_W'(1);
      end
      case ({disp_fire, commit_fire})
        2'b10:   count_d = count_q + (TAG_W+1)'(1);
        2'b01:   count_d = count_q - (TAG_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Outputs: next writeback values and a flat view of entry states.
  always_comb begin
    wb_commit_d = commit_fire;
    wb_reg_d    = '0;
    wb_data_d   = '0;
    if (commit_fire) begin
      wb_reg_d  = rd_q[head_q];
      wb_data_d = data_q[head_q];
    end
    dbg_state = '0;
    for (int i = 0; i < DEPTH; i++) dbg_state[2*i +: 2] = st_q[i];
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed scenarios with literal expectations,
// plus a queue-based program-order model compared on every falling edge.
module tb_rob_commit_unit;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic [4:0]  disp_rd = '0;
  logic        disp_ready;
  logic [2:0]  disp_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        wb_commit;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [3:0]  count;
  logic [15:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  rob_commit_unit #(.DEPTH(8), .TAG_W(3), .ADDR(5), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_rd(disp_rd),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .wb_commit(wb_commit), .wb_reg(wb_reg), .wb_data(wb_data),
    .count(count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [2:0]  m_tail   = '0;
  logic        e_commit = 1'b0;
  logic [4:0]  e_reg    = '0;
  logic [31:0] e_data   = '0;
  bit          m_take, m_ready;
  ent_t        m_tmp;

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      mq.delete();
      m_tail = '0; e_commit = 1'b0; e_reg = '0; e_data = '0;
    end else begin
      m_ready = (mq.size() != DEPTH);
      m_take  = (mq.size() > 0) && mq[0].done;
      e_commit = m_take;
      e_reg    = m_take ? mq[0].rd : 5'd0;
      e_data   = m_take ? mq[0].data : 32'd0;
      if (cdb_valid)
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].tag == cdb_tag && !mq[i].done) begin
            m_tmp = mq[i]; m_tmp.done = 1'b1; m_tmp.data = cdb_data; mq[i] = m_tmp;
          end
      if (m_take) void'(mq.pop_front());
      if (disp_valid && m_ready) begin
        m_tmp.tag = m_tail; m_tmp.rd = disp_rd; m_tmp.done = 1'b0; m_tmp.data = '0;
        mq.push_back(m_tmp);
        m_tail = m_tail + 3'd1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("m_wb_commit", 64'(wb_commit), 64'(e_commit));
      check("m_wb_reg", 64'(wb_reg), 64'(e_reg));
      check("m_wb_data", 64'(wb_data), 64'(e_data));
      check("m_count", 64'(count), 64'(mq.size()));
      check("m_disp_ready", 64'(disp_ready), 64'((mq.size() != DEPTH) && !flush));
      check("m_disp_tag", 64'(disp_tag), 64'(m_tail));
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input logic dv, input logic [4:0] drd, input logic cv,
                     input logic [2:0] ct, input logic [31:0] cd, input logic fl);
    disp_valid = dv; disp_rd = drd; cdb_valid = cv; cdb_tag = ct; cdb_data = cd; flush = fl;
    @(posedge clk); #2;
    disp_valid = 0; disp_rd = '0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0; flush = 0;
  endtask

  task automatic disp(input logic [4:0] rd);
    cyc(1'b1, rd, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic cdb(input logic [2:0] t, input logic [31:0] d);
    cyc(1'b0, 5'd0, 1'b1, t, d, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_commit", 64'(wb_commit), 64'd0);
    check("rst_tag", 64'(disp_tag), 64'd0);
    check("rst_ready", 64'(disp_ready), 64'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    do_reset();
    check_en = 1'b1;

    // 1: single instruction round trip
    disp(5'd5);
    check("t1_count1", 64'(count), 64'd1);
    check("t1_tag1", 64'(disp_tag), 64'd1);
    cdb(3'd0, 32'hDEADBEEF);
    check("t1_no_bypass", 64'(wb_commit), 64'd0);
    idle();
    check("t1_commit", 64'(wb_commit), 64'd1);
    check("t1_reg", 64'(wb_reg), 64'd5);
    check("t1_data", 64'(wb_data), 64'hDEADBEEF);
    check("t1_count0", 64'(count), 64'd0);
    idle();
    check("t1_pulse", 64'(wb_commit), 64'd0);
    check("t1_idle_reg", 64'(wb_reg), 64'd0);

    // 2: out-of-order completion, in-order retirement
    do_reset();
    disp(5'd1); disp(5'd2); disp(5'd3);
    cdb(3'd2, 32'h33);
    check("t2_wait_a", 64'(wb_commit), 64'd0);
    cdb(3'd1, 32'h22);
    check("t2_wait_b", 64'(wb_commit), 64'd0);
    idle();
    check("t2_wait_c", 64'(wb_commit), 64'd0);
    cdb(3'd0, 32'h11);
    check("t2_wait_d", 64'(wb_commit), 64'd0);
    idle();
    check("t2_x1", 64'({wb_commit, wb_reg, wb_data}), {1'b1, 5'd1, 32'h11});
    idle();
    check("t2_x2", 64'({wb_commit, wb_reg, wb_data}), {1'b1, 5'd2, 32'h22});
    idle();
    check("t2_x3", 64'({wb_commit, wb_reg, wb_data}), {1'b1, 5'd3, 32'h33});
    idle();
    check("t2_done", 64'(wb_commit), 64'd0);
    check("t2_count", 64'(count), 64'd0);

    // 3: full buffer and tail wrap
    do_reset();
    for (int i = 0; i < 8; i++) disp(5'(i + 1));
    check("t3_full_cnt", 64'(count), 64'd8);
    check("t3_full_rdy", 64'(disp_ready), 64'd0);
    disp(5'd9);
    check("t3_ignored", 64'(count), 64'd8);
    check("t3_tag_wrap", 64'(disp_tag), 64'd0);
    cdb(3'd0, 32'hA0);
    check("t3_no_reuse", 64'(disp_ready), 64'd0);
    idle();
    check("t3_commit", 64'({wb_commit, wb_reg, wb_data}), {1'b1, 5'd1, 32'hA0});
    check("t3_cnt7", 64'(count), 64'd7);
    check("t3_ready", 64'(disp_ready), 64'd1);
    check("t3_tag0", 64'(disp_tag), 64'd0);
    disp(5'd10);
    check("t3_refill", 64'(count), 64'd8);
    check("t3_tag1", 64'(disp_tag), 64'd1);

    // 4: rd=0 retires; CDB to FREE/DONE entries is ignored
    do_reset();
    disp(5'd0);
    cdb(3'd0, 32'h1234);
    idle();
    check("t4_x0", 64'({wb_commit, wb_reg, wb_data}), {1'b1, 5'd0, 32'h1234});
    cdb(3'd0, 32'h5555);
    idle();
    check("t4_dup_free", 64'(wb_commit), 64'd0);
    check("t4_cnt", 64'(count), 64'd0);
    disp(5'd7); disp(5'd8);
    cdb(3'd2, 32'hBBBB);
    cdb(3'd2, 32'hCCCC);
    cdb(3'd1, 32'hAAAA);
    idle();
    check("t4_x7", 64'({wb_commit, wb_reg, wb_data}), {1'b1, 5'd7, 32'hAAAA});
    idle();
    check("t4_x8", 64'({wb_commit, wb_reg, wb_data}), {1'b1, 5'd8, 32'hBBBB});

    // 5: flush squashes in-flight work, including a same-cycle dispatch
    do_reset();
    for (int i = 0; i < 4; i++) disp(5'(i + 4));
    cdb(3'd1, 32'h51);
    cdb(3'd2, 32'h52);
    check("t5_pre_cnt", 64'(count), 64'd4);
    disp_valid = 1'b1; disp_rd = 5'd20; flush = 1'b1;
    #1 check("t5_flush_rdy", 64'(disp_ready), 64'd0);
    @(posedge clk); #2;
    disp_valid = 1'b0; disp_rd = '0; flush = 1'b0;
    check("t5_cnt0", 64'(count), 64'd0);
    check("t5_tag0", 64'(disp_tag), 64'd0);
    check("t5_nocommit", 64'(wb_commit), 64'd0);
    cdb(3'd0, 32'h99);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("t5_quiet", 64'(wb_commit), 64'd0);
    end
    disp(5'd6);
    check("t5_redisp", 64'(count), 64'd1);
    check("t5_nexttag", 64'(disp_tag), 64'd1);

    // 6: asynchronous reset during retirement
    do_reset();
    for (int i = 0; i < 4; i++) disp(5'(i + 11));
    cdb(3'd1, 32'h61);
    cdb(3'd2, 32'h62);
    cdb(3'd0, 32'h60);
    idle();
    check("t6_commit", 64'({wb_commit, wb_reg, wb_data}), {1'b1, 5'd11, 32'h60});
    #1 rst = 1'b1;
    #1;
    check("t6_async_commit", 64'(wb_commit), 64'd0);
    check("t6_async_reg", 64'(wb_reg), 64'd0);
    check("t6_async_cnt", 64'(count), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      check("t6_quiet", 64'(wb_commit), 64'd0);
      check("t6_cnt", 64'(count), 64'd0);
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
